// File: rtl/fork_join_ctrl.sv
// fork_join_ctrl: launches three fixed-delay threads on one latched operand,
// signals when the selected join policy is first met, and combines the
// per-thread results once every thread has completed.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   start_i      launch request, sampled in IDLE only
//   mode_i[1:0]  join policy: 00 ALL, 01 ANY, 10 NONE, 11 ALL
//   in_i[DW-1:0] operand latched at launch
//   kill_i       abort all running threads
//   out_o        combined result r0^r1^r2, r[n] = in + n
//   done_o       one-cycle pulse when all threads complete and out_o updates
//   join_pt_o    one-cycle pulse when the join policy is first satisfied
//   thr_done_o   per-thread completion flags
//   busy_o       high whenever the controller is not IDLE
//   aborted_o    one-cycle pulse after a kill
module fork_join_ctrl #(
    parameter int unsigned DW       = 4,
    parameter int unsigned DLY0     = 10,
    parameter int unsigned DLY1     = 3,
    parameter int unsigned DLY2     = 0,
    parameter int unsigned HOLD_CYC = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    input  logic [1:0]    mode_i,
    input  logic [DW-1:0] in_i,
    input  logic          kill_i,
    output logic [DW-1:0] out_o,
    output logic          done_o,
    output logic          join_pt_o,
    output logic [2:0]    thr_done_o,
    output logic          busy_o,
    output logic          aborted_o
);

    localparam int unsigned CW = 8;
    localparam int unsigned HW = 4;
    localparam int unsigned NT = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q [NT];
    logic [CW-1:0]   cnt_d [NT];
    logic [HW-1:0]   hold_q, hold_d;
    logic [DW-1:0]   in_q, in_d;
    logic [1:0]      mode_q, mode_d;
    logic [DW-1:0]   out_q, out_d;
    logic [2:0]      thr_q, thr_d;
    logic            done_q, done_d;
    logic            join_q, join_d;
    logic            busy_q, busy_d;
    logic            aborted_q, aborted_d;
    logic [DW-1:0]   combined_c;

    // Join policy evaluated against a given flag set
    function automatic logic policy_met(input logic [1:0] md, input logic [2:0] flags);
        logic met;
        case (md)
            2'b01:   met = |flags;
            2'b10:   met = 1'b1;
            default: met = &flags;
        endcase
        return met;
    endfunction

    assign combined_c = in_q ^ (in_q + DW'(1)) ^ (in_q + DW'(2));

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            for (int n = 0; n < int'(NT); n++) cnt_q[n] <= '0;
            hold_q    <= '0;
            in_q      <= '0;
            mode_q    <= '0;
            out_q     <= '0;
            thr_q     <= '0;
            done_q    <= 1'b0;
            join_q    <= 1'b0;
            busy_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            for (int n = 0; n < int'(NT); n++) cnt_q[n] <= cnt_d[n];
            hold_q    <= hold_d;
            in_q      <= in_d;
            mode_q    <= mode_d;
            out_q     <= out_d;
            thr_q     <= thr_d;
            done_q    <= done_d;
            join_q    <= join_d;
            busy_q    <= busy_d;
            aborted_q <= aborted_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        for (int n = 0; n < int'(NT); n++) cnt_d[n] = cnt_q[n];
        hold_d    = hold_q;
        in_d      = in_q;
        mode_d    = mode_q;
        out_d     = out_q;
        thr_d     = thr_q;
        done_d    = 1'b0;
        aborted_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i && !kill_i) begin
                    in_d     = in_i;
                    mode_d   = mode_i;
                    cnt_d[0] = CW'(DLY0);
                    cnt_d[1] = CW'(DLY1);
                    cnt_d[2] = CW'(DLY2);
                    thr_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN, WAIT: begin
                for (int n = 0; n < int'(NT); n++) begin
                    if (cnt_q[n] == '0) thr_d[n] = 1'b1;
                    else                cnt_d[n] = cnt_q[n] - CW'(1);
                end
                // Completion takes priority over the RUN->WAIT step after a join
                if (&thr_q) begin
                    out_d   = combined_c;
                    done_d  = 1'b1;
                    hold_d  = HW'(HOLD_CYC - 1);
                    state_d = HOLD;
                end else if (state_q == RUN && join_q) begin
                    state_d = WAIT;
                end
            end
            HOLD: begin
                if (hold_q == '0) state_d = IDLE;
                else              hold_d  = hold_q - HW'(1);
            end
            default: state_d = IDLE;
        endcase

        // Kill overrides everything outside IDLE, including a coincident completion
        if (kill_i && state_q != IDLE) begin
            state_d   = IDLE;
            thr_d     = '0;
            out_d     = out_q;
            done_d    = 1'b0;
            aborted_d = 1'b1;
        end

        // join_q can only be high on one RUN cycle because RUN leaves on the next edge
        join_d = (state_d == RUN) && policy_met(mode_d, thr_d);
        busy_d = (state_d != IDLE);
    end

    assign out_o      = out_q;
    assign done_o     = done_q;
    assign join_pt_o  = join_q;
    assign thr_done_o = thr_q;
    assign busy_o     = busy_q;
    assign aborted_o  = aborted_q;

endmodule

// File: tb/tb_fork_join_ctrl.sv
module tb_fork_join_ctrl;

    localparam int unsigned DW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start_i;
    logic [1:0]    mode_i;
    logic [DW-1:0] in_i;
    logic          kill_i;
    logic [DW-1:0] out_o;
    logic          done_o;
    logic          join_pt_o;
    logic [2:0]    thr_done_o;
    logic          busy_o;
    logic          aborted_o;

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] last_out = '0;

    fork_join_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .mode_i     (mode_i),
        .in_i       (in_i),
        .kill_i     (kill_i),
        .out_o      (out_o),
        .done_o     (done_o),
        .join_pt_o  (join_pt_o),
        .thr_done_o (thr_done_o),
        .busy_o     (busy_o),
        .aborted_o  (aborted_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] ref_out(input logic [DW-1:0] a);
        logic [DW-1:0] r0, r1, r2;
        r0 = a;
        r1 = a + DW'(1);
        r2 = a + DW'(2);
        return r0 ^ r1 ^ r2;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; start_i = 1'b0; kill_i = 1'b0; mode_i = '0; in_i = '0;
        step(); step();
        total++;
        if ({out_o, done_o, join_pt_o, thr_done_o, busy_o, aborted_o} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%0h exp=0",
                     {out_o, done_o, join_pt_o, thr_done_o, busy_o, aborted_o});
        end
        rst_n = 1'b1;
        step();
        total++;
        if (busy_o !== 1'b0) begin
            bad++; $display("FAIL reset_release_busy got=%0b exp=0", busy_o);
        end
    endtask

    // Launch one transaction and check every cycle through return to IDLE.
    // With hold_start, start stays high and a relaunch is expected at E15.
    task automatic run_check(input logic [1:0] md, input logic [DW-1:0] din,
                             input int join_e, input string nm, input bit hold_start);
        logic [2:0]    exp_thr;
        logic [DW-1:0] got, want, in2;
        bit            seen_done;
        seen_done = 0;
        mode_i = md; in_i = din; start_i = 1'b1;
        exp_q.push_back(ref_out(din));
        step();                                    // E0
        if (!hold_start) start_i = 1'b0;
        in2  = ~din;
        in_i = in2;                                // must not affect the latched operand
        for (int e = 0; e <= 14; e++) begin
            if (e > 0) step();
            exp_thr = {e >= 1, e >= 4, e >= 11};
            total++;
            if (join_pt_o !== (e == join_e)) begin
                bad++; $display("FAIL %s join_pt E%0d got=%0b exp=%0b", nm, e, join_pt_o, e == join_e);
            end
            total++;
            if (done_o !== (e == 12)) begin
                bad++; $display("FAIL %s done E%0d got=%0b exp=%0b", nm, e, done_o, e == 12);
            end
            total++;
            if (busy_o !== (e < 14)) begin
                bad++; $display("FAIL %s busy E%0d got=%0b exp=%0b", nm, e, busy_o, e < 14);
            end
            if (e < 14) begin
                total++;
                if (thr_done_o !== exp_thr) begin
                    bad++; $display("FAIL %s thr_done E%0d got=%b exp=%b", nm, e, thr_done_o, exp_thr);
                end
            end
            if (done_o === 1'b1) begin
                seen_done = 1;
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL %s unexpected_done got=1 exp=0", nm);
                end else begin
                    want = exp_q.pop_front();
                    got  = out_o;
                    if (got !== want) begin
                        bad++; $display("FAIL %s out got=%0h exp=%0h", nm, got, want);
                    end
                    last_out = want;
                end
            end
        end
        if (!seen_done) begin
            total++; bad++; $display("FAIL %s done_timeout got=0 exp=1", nm);
        end
        if (hold_start) begin
            exp_q.push_back(ref_out(in2));
            step();                                // E15: start sampled in IDLE
            start_i = 1'b0;
            total++;
            if (busy_o !== 1'b1) begin
                bad++; $display("FAIL %s relaunch_busy got=%0b exp=1", nm, busy_o);
            end
            seen_done = 0;
            for (int k = 0; k < 20 && !seen_done; k++) begin
                step();
                if (done_o === 1'b1) begin
                    seen_done = 1;
                    total++;
                    want = exp_q.pop_front();
                    if (out_o !== want) begin
                        bad++; $display("FAIL %s relaunch_out got=%0h exp=%0h", nm, out_o, want);
                    end
                    last_out = want;
                end
            end
            if (!seen_done) begin
                total++; bad++; $display("FAIL %s relaunch_timeout got=0 exp=1", nm);
            end
            step(); step(); step();
        end
    endtask

    task automatic test_none(); run_check(2'b10, 4'd15, 0, "none", 0); endtask
    task automatic test_any();  run_check(2'b01, 4'd3, 1, "any", 0);   endtask
    task automatic test_all();  run_check(2'b00, 4'd3, 11, "all", 0);  endtask
    task automatic test_mode3(); run_check(2'b11, 4'd7, 11, "mode3", 0); endtask

    task automatic test_kill();
        bit saw_done;
        saw_done = 0;
        mode_i = 2'b00; in_i = 4'd5; start_i = 1'b1;
        step();                                    // E0
        start_i = 1'b0;
        for (int e = 1; e <= 5; e++) step();
        kill_i = 1'b1;
        step();                                    // E6
        kill_i = 1'b0;
        total++;
        if (aborted_o !== 1'b1) begin bad++; $display("FAIL kill_aborted got=%0b exp=1", aborted_o); end
        total++;
        if (busy_o !== 1'b0) begin bad++; $display("FAIL kill_busy got=%0b exp=0", busy_o); end
        total++;
        if (out_o !== last_out) begin bad++; $display("FAIL kill_out got=%0h exp=%0h", out_o, last_out); end
        total++;
        if (thr_done_o !== 3'b000) begin bad++; $display("FAIL kill_thr got=%b exp=000", thr_done_o); end
        step();
        total++;
        if (aborted_o !== 1'b0) begin bad++; $display("FAIL kill_aborted_pulse got=%0b exp=0", aborted_o); end
        for (int k = 0; k < 12; k++) begin
            step();
            if (done_o === 1'b1) saw_done = 1;
        end
        total++;
        if (saw_done) begin bad++; $display("FAIL kill_no_done got=1 exp=0"); end
        // kill with start in IDLE: no launch, no abort
        kill_i = 1'b1; start_i = 1'b1;
        step();
        kill_i = 1'b0; start_i = 1'b0;
        total++;
        if ({busy_o, aborted_o} !== 2'b00) begin
            bad++; $display("FAIL idle_kill_start got=%b exp=00", {busy_o, aborted_o});
        end
        step();
    endtask

    task automatic test_back_to_back(); run_check(2'b00, 4'd3, 11, "b2b", 1); endtask

    task automatic test_reset_mid();
        mode_i = 2'b00; in_i = 4'd3; start_i = 1'b1;
        step();                                    // E0
        start_i = 1'b0;
        for (int e = 1; e <= 4; e++) step();
        rst_n = 1'b0;
        step();                                    // E5
        total++;
        if ({out_o, done_o, join_pt_o, thr_done_o, busy_o, aborted_o} !== '0) begin
            bad++;
            $display("FAIL midrun_reset got=%0h exp=0",
                     {out_o, done_o, join_pt_o, thr_done_o, busy_o, aborted_o});
        end
        rst_n = 1'b1;
        step();
        total++;
        if ({done_o, aborted_o, busy_o} !== 3'b000) begin
            bad++; $display("FAIL midrun_reset_after got=%b exp=000", {done_o, aborted_o, busy_o});
        end
        last_out = '0;
        run_check(2'b00, 4'd1, 11, "post_reset", 0);
    endtask

    initial begin
        test_reset();
        test_none();
        test_any();
        test_mode3();
        test_all();
        test_kill();
        test_back_to_back();
        test_reset_mid();
        total++;
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fork_join_ctrl.md
FORK_JOIN_CTRL -- requirements
Module: fork_join_ctrl

Interface
REQ-001 Parameter DW, default 4: data width of in, out and per-thread results.
REQ-002 Parameter DLY0, default 10: thread 0 completion delay in cycles, range 0..255.
REQ-003 Parameter DLY1, default 3: thread 1 completion delay in cycles, range 0..255.
REQ-004 Parameter DLY2, default 0: thread 2 completion delay in cycles, range 0..255.
REQ-005 Parameter HOLD_CYC, default 2: post-completion hold cycles, range 1..15.
REQ-006 The block SHALL use one clock; reset is synchronous and active-low.
REQ-007 clk  input  1  rising-edge clock.
REQ-008 rst_n  input  1  synchronous active-low reset.
REQ-009 start  input  1  launch request, sampled in IDLE only.
REQ-010 mode  input  2  join policy: 00 ALL, 01 ANY, 10 NONE, 11 treated as ALL.
REQ-011 in  input  DW  operand latched at launch.
REQ-012 kill  input  1  abort all running threads.
REQ-013 out  output  DW  combined result of all three threads.
REQ-014 done  output  1  one-cycle pulse: all threads complete, out updated.
REQ-015 join_pt  output  1  one-cycle pulse: join policy first satisfied.
REQ-016 thr_done  output  3  per-thread completion flags.
REQ-017 busy  output  1  high whenever state is not IDLE.
REQ-018 aborted  output  1  one-cycle pulse after a kill.

Function
REQ-019 States SHALL be IDLE, RUN, WAIT, HOLD; busy = (state != IDLE).
REQ-020 In IDLE, start=1 at edge E0 SHALL latch in and mode, load cnt[n]=DLYn, clear thr_done, and enter RUN.
REQ-021 Each RUN/WAIT edge, per thread: cnt[n]==0 sets thr_done[n], else cnt[n] decrements; thr_done[n] therefore rises after edge E(DLYn+1) and holds until IDLE.
REQ-022 join_pt SHALL be high for exactly one cycle: the first RUN cycle in which the latched policy is met (ALL: all flags set; ANY: any flag set; NONE: immediately, cycle after E0); the next edge moves RUN to WAIT.
REQ-023 Thread result r[n] = in_latched + n, modulo 2^DW; the combined result is r0 XOR r1 XOR r2.
REQ-024 At the first RUN/WAIT edge with all thr_done set, the block SHALL load out with the combined result, pulse done for one cycle, and enter HOLD; ALL mode may skip WAIT.
REQ-025 HOLD SHALL last exactly HOLD_CYC cycles, then IDLE; start is ignored outside IDLE.
REQ-026 kill=1 in RUN, WAIT or HOLD SHALL, at that edge, enter IDLE, clear thr_done and pulse aborted; out is unchanged and done is not pulsed.
REQ-027 If kill and thread completion coincide on the same edge, kill SHALL win.
REQ-028 kill in IDLE SHALL have no effect; kill and start together in IDLE: start is ignored.
REQ-029 Defaults: ANY join_pt after E1; ALL join_pt after E11; done after E12 in all modes; IDLE after E14.

Reset
REQ-030 rst_n=0 at an edge SHALL force IDLE and clear all counters; out, thr_done, done, join_pt, busy and aborted all read 0.
REQ-031 Reset SHALL take effect from any state, including mid-RUN, with no done or aborted pulse.

Verification
REQ-032 ALL mode, in=3, start at E0 -> join_pt after E11; done after E12 with out=2; busy low after E14.
REQ-033 ANY mode, in=3 -> thr_done=100 after E1 and join_pt after E1; thr_done=110 after E4; done after E12 with out=2.
REQ-034 NONE mode, in=15 -> join_pt in the cycle after E0; done after E12 with out=14 (wrap: 15, 0, 1).
REQ-035 kill at E6 in ALL mode with prior out=2 -> aborted after E6; IDLE; out stays 2; no done; thr_done=000.
REQ-036 start held high during RUN -> single launch; a new start is accepted only from IDLE (sampled at E15).
REQ-037 rst_n=0 at E5 mid-RUN -> all outputs 0 after E5; a subsequent start with in=1 produces out=0 (1^2^3).
